// File: rtl/piecewise_fixed_pkg.sv
// Shared word/product/sum types and result-shaping helpers for the piecewise-linear evaluator.
// The widths here set the defaults for the piecewise_fixed WID/FBITS parameters.
package piecewise_fixed_pkg;

    localparam int FX_WID   = 16;
    localparam int FX_FBITS = 8;

    typedef logic signed [FX_WID-1:0]   word_t;
    typedef logic signed [2*FX_WID-1:0] prod_t;
    typedef logic signed [2*FX_WID:0]   sum_t;

    localparam word_t WORD_MAX = {1'b0, {(FX_WID-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(FX_WID-1){1'b0}}};

    // The sum fits a word only when every bit from the word's sign bit upward matches.
    function automatic logic fx_ovf(input sum_t s);
        logic [FX_WID+1:0] upper;
        upper = s[2*FX_WID:FX_WID-1];
        return !((&upper) || (~|upper));
    endfunction

    function automatic word_t fx_sat(input sum_t s);
        if (fx_ovf(s))
            return s[2*FX_WID] ? WORD_MIN : WORD_MAX;
        return word_t'(s[FX_WID-1:0]);
    endfunction

    function automatic word_t fx_wrap(input sum_t s);
        return word_t'(s[FX_WID-1:0]);
    endfunction

endpackage

// File: rtl/piecewise_fixed_mac.sv
// fixp_mac: offset + (slope*x >>> FBITS), evaluated at full precision.
// The 2*WID+1-bit result cannot overflow for any WID-bit operands.
module fixp_mac #(
    parameter int WID   = 16,
    parameter int FBITS = 8
) (
    input  logic signed [WID-1:0] offset,
    input  logic signed [WID-1:0] slope,
    input  logic signed [WID-1:0] x,
    output logic signed [2*WID:0] s
);

    logic signed [2*WID-1:0] prod;
    logic signed [2*WID-1:0] prodShift;

    assign prod      = slope * x;
    assign prodShift = prod >>> FBITS;

    assign s = $signed({{(WID+1){offset[WID-1]}}, offset}) +
               $signed({prodShift[2*WID-1], prodShift});

endmodule

// File: rtl/piecewise_fixed.sv
// Signed fixed-point piecewise-linear evaluator: y = a0 + a1*x (x<0) else a2 + a3*x, one register stage.
// Optional PIECEWISE_FIXED_OVF_FLAG_EN adds an ovf output flagging sums outside the word range.
module piecewise_fixed
    import piecewise_fixed_pkg::*;
#(
    parameter int WID      = FX_WID,
    parameter int FBITS    = FX_FBITS,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [WID-1:0] x,
    input  logic signed [WID-1:0] a0,
    input  logic signed [WID-1:0] a1,
    input  logic signed [WID-1:0] a2,
    input  logic signed [WID-1:0] a3,
`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
    output logic                  ovf,
`endif
    output logic signed [WID-1:0] y
);

    logic signed [WID-1:0] x_q, a0_q, a1_q, a2_q, a3_q;
    logic signed [WID-1:0] offset, slope;
    logic signed [2*WID:0] s;

    // Every operand is captured unconditionally; reset zeroes them, which makes y read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            a0_q <= '0;
            a1_q <= '0;
            a2_q <= '0;
            a3_q <= '0;
        end else begin
            x_q  <= x;
            a0_q <= a0;
            a1_q <= a1;
            a2_q <= a2;
            a3_q <= a3;
        end
    end

    // x == 0 has a clear sign bit and therefore uses the non-negative segment.
    assign offset = x_q[WID-1] ? a0_q : a2_q;
    assign slope  = x_q[WID-1] ? a1_q : a3_q;

    fixp_mac #(
        .WID   (WID),
        .FBITS (FBITS)
    ) u_mac (
        .offset (offset),
        .slope  (slope),
        .x      (x_q),
        .s      (s)
    );

    always_comb begin
        y = '0;
        if (SATURATE)
            y = fx_sat(s);
        else
            y = fx_wrap(s);
    end

`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
    assign ovf = fx_ovf(s);
`endif

endmodule

// File: tb/tb_piecewise_fixed.sv
// Directed-vector and random-sweep bench for piecewise_fixed, run on a saturating and a wrapping instance.
// Checks ovf too when PIECEWISE_FIXED_OVF_FLAG_EN is defined.
module tb_piecewise_fixed;

    typedef struct {
        string             name;
        logic signed [15:0] x, a0, a1, a2, a3;
        logic signed [15:0] ySat, yWrap;
        logic               ovf;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] x, a0, a1, a2, a3;
    logic signed [15:0] ySat, yWrap;
`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
    logic               ovfSat, ovfWrap;
`endif

    int vecCount  = 0;
    int missCount = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    piecewise_fixed #(.WID(16), .FBITS(8), .SATURATE(1'b1)) dutSat (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
        .ovf   (ovfSat),
`endif
        .y     (ySat)
    );

    piecewise_fixed #(.WID(16), .FBITS(8), .SATURATE(1'b0)) dutWrap (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
        .ovf   (ovfWrap),
`endif
        .y     (yWrap)
    );

    function automatic vec_t mkVec(string n, int xv, int a0v, int a1v, int a2v, int a3v,
                                   int ys, int yw, bit ov);
        vec_t v;
        v.name = n;
        v.x = 16'(xv); v.a0 = 16'(a0v); v.a1 = 16'(a1v); v.a2 = 16'(a2v); v.a3 = 16'(a3v);
        v.ySat = 16'(ys); v.yWrap = 16'(yw); v.ovf = ov;
        return v;
    endfunction

    // Golden integer model: 64-bit arithmetic, then clamp or wrap to 16 bits.
    function automatic void model(input logic signed [15:0] xv, a0v, a1v, a2v, a3v,
                                  output logic signed [15:0] sat, output logic signed [15:0] wrap,
                                  output logic ov);
        longint off, sl, p, s;
        off = (xv < 0) ? longint'(a0v) : longint'(a2v);
        sl  = (xv < 0) ? longint'(a1v) : longint'(a3v);
        p   = sl * longint'(xv);
        s   = off + (p >>> 8);
        ov  = (s > 32767) || (s < -32768);
        if (s > 32767)       sat = 16'sh7fff;
        else if (s < -32768) sat = 16'sh8000;
        else                 sat = s[15:0];
        wrap = s[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic signed [15:0] es,
                            input logic signed [15:0] ew, input logic eo);
        checkOutput({name, " ySat"}, ySat, es);
        checkOutput({name, " yWrap"}, yWrap, ew);
`ifdef PIECEWISE_FIXED_OVF_FLAG_EN
        checkOutput({name, " ovfSat"}, {31'b0, ovfSat}, {31'b0, eo});
        checkOutput({name, " ovfWrap"}, {31'b0, ovfWrap}, {31'b0, eo});
`else
        if (eo === 1'bx) checkOutput({name, " ovf-model"}, 0, 1);
`endif
    endtask

    task automatic driveVec(input vec_t v);
        x = v.x; a0 = v.a0; a1 = v.a1; a2 = v.a2; a3 = v.a3;
    endtask

    // Called 1 time unit after a posedge: drive, wait one edge, check.
    task automatic applyStimulus(input vec_t v);
        driveVec(v);
        @(posedge clk); #1;
        checkAll(v.name, v.ySat, v.yWrap, v.ovf);
    endtask

    initial begin
        logic signed [15:0] es, ew;
        logic               eo;
        vec_t               r;

        vecs[0]  = mkVec("pos_seg",     256,    0,      0,   0,     512,    512,    512,    0);
        vecs[1]  = mkVec("neg_seg",    -256,  256,    256,   0,       0,      0,      0,    0);
        vecs[2]  = mkVec("zero_x",        0,  256,    256,   7,       0,      7,      7,    0);
        vecs[3]  = mkVec("floor_pos",     1,    0,      0,   0,     128,      0,      0,    0);
        vecs[4]  = mkVec("floor_neg",    -1,    0,    128,   0,       0,     -1,     -1,    0);
        vecs[5]  = mkVec("ovf_pos",   25600,    0,      0,   0,     512,  32767, -14336,    1);
        vecs[6]  = mkVec("ovf_neg",  -25600,    0,    512,   0,       0, -32768,  14336,    1);
        vecs[7]  = mkVec("max_exact",   256,    0,      0, 32767,     0,  32767,  32767,    0);
        vecs[8]  = mkVec("max_plus1",   256,    0,      0, 32767,     1,  32767, -32768,    1);
        vecs[9]  = mkVec("min_minus1", -256, -32768,    1,   0,       0, -32768,  32767,    1);
        vecs[10] = mkVec("min_sq",   -32768, -32768, -32768, 0,       0,  32767, -32768,    1);
        vecs[11] = mkVec("floor_mid",    -3,  100,     85,   0,       0,     99,     99,    0);

        // Reset held with random inputs: output must stay zero across edges.
        rst_n = 1'b0;
        x = 16'($urandom); a0 = 16'($urandom); a1 = 16'($urandom);
        a2 = 16'($urandom); a3 = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset_hold", 16'sd0, 16'sd0, 1'b0);

        rst_n = 1'b1;
        applyStimulus(vecs[0]);

        // Latency: new inputs must not show before the next edge.
        driveVec(vecs[5]);
        #2;
        checkAll("hold_prev", 16'sd512, 16'sd512, 1'b0);
        @(posedge clk); #1;
        checkAll("after_edge", vecs[5].ySat, vecs[5].yWrap, vecs[5].ovf);

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i]);

        // Asynchronous reset mid-cycle clears the output without a clock edge.
        driveVec(vecs[5]);
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        checkAll("async_reset", 16'sd0, 16'sd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkAll("reset_release", 16'sd0, 16'sd0, 1'b0);
        @(posedge clk); #1;
        checkAll("resume", vecs[5].ySat, vecs[5].yWrap, vecs[5].ovf);

        for (int i = 0; i < 200; i++) begin
            r.name = "random";
            r.x  = 16'($urandom); r.a0 = 16'($urandom); r.a1 = 16'($urandom);
            r.a2 = 16'($urandom); r.a3 = 16'($urandom);
            if (i % 2 == 0) begin
                r.a0 = 16'($signed(r.a0) >>> 6); r.a2 = 16'($signed(r.a2) >>> 6);
                r.a1 = 16'($signed(r.a1) >>> 4); r.a3 = 16'($signed(r.a3) >>> 4);
            end
            model(r.x, r.a0, r.a1, r.a2, r.a3, es, ew, eo);
            r.ySat = es; r.yWrap = ew; r.ovf = eo;
            applyStimulus(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
